branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve.sv | 115 +++++++++++
 tb/tb_branch_resolve.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - two-port branch mispredict resolver with one deferred slot
// Picks the oldest taken branch by ROB age and holds it as a registered redirect request.
module branch_resolve #(
  parameter int ROB_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br0_valid_i,
  input  logic             br0_taken_i,
  input  logic [ROB_W-1:0] br0_tag_i,
  input  logic [31:0]      br0_target_i,
  input  logic             br1_valid_i,
  input  logic             br1_taken_i,
  input  logic [ROB_W-1:0] br1_tag_i,
  input  logic [31:0]      br1_target_i,
  input  logic [ROB_W-1:0] rob_head_i,
  input  logic             flush_i,
  output logic             mispredict_o,
  output logic [31:0]      target_pc_o,
  output logic [ROB_W-1:0] recover_tag_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] mp_count_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]       state_q;
  logic [ROB_W-1:0] pend_tag_q;
  logic [31:0]      pend_tgt_q;
  logic             def_valid_q;
  logic [ROB_W-1:0] def_tag_q;
  logic [31:0]      def_tgt_q;
  logic [CNT_W-1:0] cnt_q;

  logic             c0, c1, pick1;
  logic [ROB_W-1:0] age0, age1, pend_age, def_age;
  logic             best_valid;
  logic [ROB_W-1:0] best_tag, best_age;
  logic [31:0]      best_tgt;
  logic             cand_older, take_def, merge;

  // Ages are distances from the ROB head; unsigned wrap makes older = smaller.
  assign c0       = br0_valid_i & br0_taken_i;
  assign c1       = br1_valid_i & br1_taken_i;
  assign age0     = br0_tag_i - rob_head_i;
  assign age1     = br1_tag_i - rob_head_i;
  assign pend_age = pend_tag_q - rob_head_i;
  assign def_age  = def_tag_q - rob_head_i;

  // Port 0 wins ties, so port 1 only takes over when strictly older.
  assign pick1      = c1 & (~c0 | (age1 < age0));
  assign best_valid = c0 | c1;
  assign best_tag   = pick1 ? br1_tag_i    : br0_tag_i;
  assign best_tgt   = pick1 ? br1_target_i : br0_target_i;
  assign best_age   = pick1 ? age1         : age0;

  // Only the best same-cycle candidate can matter: the other is younger than it.
  assign cand_older = best_valid & (best_age < pend_age);
  assign merge      = cand_older & (~def_valid_q | (best_age < def_age));
  assign take_def   = def_valid_q & (~cand_older | (def_age <= best_age));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pend_tag_q  <= '0;
      pend_tgt_q  <= '0;
      def_valid_q <= 1'b0;
      def_tag_q   <= '0;
      def_tgt_q   <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (best_valid) begin
            pend_tag_q <= best_tag;
            pend_tgt_q <= best_tgt;
            state_q    <= S_HOLD;
            if (cnt_q != '1) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_HOLD: begin
          if (merge) begin
            def_valid_q <= 1'b1;
            def_tag_q   <= best_tag;
            def_tgt_q   <= best_tgt;
          end
          if (flush_i) state_q <= S_GAP;
        end
        S_GAP: begin
          // Whatever is not chosen here is younger than the new pending and gets squashed.
          if (take_def || cand_older) begin
            pend_tag_q  <= take_def ? def_tag_q : best_tag;
            pend_tgt_q  <= take_def ? def_tgt_q : best_tgt;
            def_valid_q <= 1'b0;
            state_q     <= S_HOLD;
            if (cnt_q != '1) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mispredict_o  = (state_q == S_HOLD);
  assign busy_o        = (state_q != S_IDLE);
  assign target_pc_o   = pend_tgt_q;
  assign recover_tag_o = pend_tag_q;
  assign mp_count_o    = cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - directed scoreboard bench for branch_resolve
// Expected redirects are queued at stimulus time and checked on each request rising edge.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br0_valid_i, br0_taken_i, br1_valid_i, br1_taken_i;
  logic [3:0]  br0_tag_i, br1_tag_i, rob_head_i;
  logic [31:0] br0_target_i, br1_target_i;
  logic        flush_i;
  logic        mispredict_o, busy_o;
  logic [31:0] target_pc_o;
  logic [3:0]  recover_tag_o;
  logic [3:0]  mp_count_o;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] pc;
    logic [3:0]  cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [3:0]  exp_cnt  = 4'd0;
  logic        mp_prev  = 1'b0;
  logic [3:0]  held_tag;
  logic [31:0] held_pc;

  branch_resolve #(.ROB_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .br0_valid_i(br0_valid_i), .br0_taken_i(br0_taken_i),
    .br0_tag_i(br0_tag_i), .br0_target_i(br0_target_i),
    .br1_valid_i(br1_valid_i), .br1_taken_i(br1_taken_i),
    .br1_tag_i(br1_tag_i), .br1_target_i(br1_target_i),
    .rob_head_i(rob_head_i), .flush_i(flush_i),
    .mispredict_o(mispredict_o), .target_pc_o(target_pc_o),
    .recover_tag_o(recover_tag_o), .busy_o(busy_o), .mp_count_o(mp_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic push(input logic [3:0] tag, input logic [31:0] pc);
    exp_t e;
    exp_cnt = (exp_cnt == 4'hf) ? 4'hf : exp_cnt + 4'd1;
    e.tag = tag; e.pc = pc; e.cnt = exp_cnt;
    sb.push_back(e);
  endtask

  task automatic set0(input logic [3:0] tag, input logic [31:0] pc);
    br0_valid_i = 1'b1; br0_taken_i = 1'b1; br0_tag_i = tag; br0_target_i = pc;
  endtask

  task automatic set1(input logic [3:0] tag, input logic [31:0] pc);
    br1_valid_i = 1'b1; br1_taken_i = 1'b1; br1_tag_i = tag; br1_target_i = pc;
  endtask

  task automatic clr();
    br0_valid_i = 1'b0; br0_taken_i = 1'b0; br0_tag_i = '0; br0_target_i = '0;
    br1_valid_i = 1'b0; br1_taken_i = 1'b0; br1_tag_i = '0; br1_target_i = '0;
  endtask

  task automatic flush_to_idle(input string name);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    chk({name, "_gap_mp"}, mispredict_o, 0);
    chk({name, "_gap_busy"}, busy_o, 1);
    cyc();
    chk({name, "_idle_busy"}, busy_o, 0);
  endtask

  // Scoreboard: pop on every rising request, and hold-stability while it stays high.
  always @(negedge clk) begin
    if (mispredict_o && !mp_prev) begin
      if (sb.size() == 0) begin
        chk("unexpected_request", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_tag", recover_tag_o, e.tag);
        chk("sb_pc", target_pc_o, e.pc);
        chk("sb_cnt", mp_count_o, e.cnt);
      end
      held_tag = recover_tag_o;
      held_pc  = target_pc_o;
    end else if (mispredict_o && mp_prev) begin
      chk("hold_tag_stable", recover_tag_o, held_tag);
      chk("hold_pc_stable", target_pc_o, held_pc);
    end
    mp_prev = mispredict_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; rob_head_i = '0;
    clr();
    repeat (2) cyc();
    chk("rst_mp", mispredict_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_cnt", mp_count_o, 0);
    chk("rst_tag", recover_tag_o, 0);
    chk("rst_pc", target_pc_o, 0);
    rst_n = 1'b1;
    cyc();

    // single mispredict
    rob_head_i = 4'd0;
    set0(4'd3, 32'h100); push(4'd3, 32'h100);
    cyc(); clr();
    chk("single_mp", mispredict_o, 1);
    chk("single_busy", busy_o, 1);
    flush_to_idle("single");

    // dual same-cycle: port1 older across wrap
    rob_head_i = 4'd14;
    set0(4'd1, 32'hA0); set1(4'd15, 32'hB0); push(4'd15, 32'hB0);
    cyc(); clr();
    chk("dual_tag", recover_tag_o, 15);
    flush_to_idle("dual");

    // older candidate arrives during HOLD -> deferred, reissued after GAP
    rob_head_i = 4'd0;
    set0(4'd6, 32'h300); push(4'd6, 32'h300);
    cyc();
    set0(4'd4, 32'h200); push(4'd4, 32'h200);
    cyc(); clr();
    chk("defer_hold_pc", target_pc_o, 32'h300);
    cyc();
    chk("defer_hold_tag", recover_tag_o, 6);
    flush_i = 1'b1;
    cyc(); flush_i = 1'b0;
    chk("defer_gap_mp", mispredict_o, 0);
    cyc();
    chk("defer_reissue_mp", mispredict_o, 1);
    chk("defer_reissue_tag", recover_tag_o, 4);
    flush_to_idle("defer");

    // older candidate arriving in the GAP cycle itself; port0 younger one is dropped
    set0(4'd9, 32'h90); push(4'd9, 32'h90);
    cyc(); clr();
    flush_i = 1'b1;
    cyc(); flush_i = 1'b0;
    set0(4'd12, 32'hC0); set1(4'd2, 32'h22); push(4'd2, 32'h22);
    cyc(); clr();
    chk("gapcand_tag", recover_tag_o, 2);
    flush_to_idle("gapcand");

    // not-taken filtering
    br0_valid_i = 1'b1; br1_valid_i = 1'b1; br0_tag_i = 4'd1; br1_tag_i = 4'd2;
    repeat (3) cyc();
    chk("nt_mp", mispredict_o, 0);
    chk("nt_cnt", mp_count_o, exp_cnt);
    clr();

    // wrap-around age compare
    rob_head_i = 4'd12;
    set0(4'd2, 32'h2); set1(4'd13, 32'hD); push(4'd13, 32'hD);
    cyc(); clr();
    chk("wrap_tag", recover_tag_o, 13);
    flush_to_idle("wrap");

    // equal age: port 0 wins
    rob_head_i = 4'd0;
    set0(4'd5, 32'h50); set1(4'd5, 32'h51); push(4'd5, 32'h50);
    cyc(); clr();
    chk("tie_pc", target_pc_o, 32'h50);
    flush_to_idle("tie");

    // drive the counter into saturation
    for (int i = 0; i < 10; i++) begin
      set0(4'(i), 32'h1000 + 32'(i)); push(4'(i), 32'h1000 + 32'(i));
      cyc(); clr();
      flush_to_idle("sat");
    end
    chk("sat_cnt", mp_count_o, 15);

    // reset in the middle of HOLD with a deferred entry pending
    set0(4'd7, 32'h70); push(4'd7, 32'h70);
    cyc(); clr();
    set1(4'd1, 32'h10);
    cyc(); clr();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_mp", mispredict_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_pc", target_pc_o, 0);
    chk("midrst_tag", recover_tag_o, 0);
    chk("midrst_cnt", mp_count_o, 0);
    exp_cnt = 4'd0;
    cyc();
    rst_n = 1'b1;
    repeat (6) cyc();
    chk("postrst_mp", mispredict_o, 0);
    chk("postrst_busy", busy_o, 0);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
